// File: rtl/pipeline_stall_controller_if.sv
// Signal bundle between the stall controller, the pipeline registers and the SRAM port.
// The controller is the master: it drives the freeze/flush/request outputs.
interface pipeline_stall_controller_if;
   logic        hazard_detected;
   logic        branch_taken;
   logic        MEM_R_EN_MEM;
   logic        MEM_W_EN_MEM;
   logic        sram_ready;
   logic        sram_req;
   logic        pc_freeze;
   logic        IF_ID_freeze;
   logic        ID_EXE_freeze;
   logic        EXE_MEM_freeze;
   logic        IF_ID_flush;
   logic        ID_EXE_bubble;
   logic        mem_timeout;
   logic [31:0] stall_count;

   modport master (
      input  hazard_detected, branch_taken, MEM_R_EN_MEM, MEM_W_EN_MEM, sram_ready,
      output sram_req, pc_freeze, IF_ID_freeze, ID_EXE_freeze, EXE_MEM_freeze,
             IF_ID_flush, ID_EXE_bubble, mem_timeout, stall_count
   );

   modport slave (
      output hazard_detected, branch_taken, MEM_R_EN_MEM, MEM_W_EN_MEM, sram_ready,
      input  sram_req, pc_freeze, IF_ID_freeze, ID_EXE_freeze, EXE_MEM_freeze,
             IF_ID_flush, ID_EXE_bubble, mem_timeout, stall_count
   );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller: freezes the pipe around SRAM accesses (RUN/WAIT/RELEASE FSM with
// timeout), inserts bubbles on data hazards and flushes IF/ID on taken branches.
// Optional macro STALL_COUNTER_EN enables a saturating stall-cycle counter on stall_count.
module pipeline_stall_controller #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   pipeline_stall_controller_if.master   ctl
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       sram_req_q;
   logic       mem_timeout_q;
   logic       mem_access;
   logic       mem_busy;
   logic       timeout_hit;

   logic pc_freeze_c, if_id_freeze_c, id_exe_freeze_c, exe_mem_freeze_c;
   logic if_id_flush_c, id_exe_bubble_c;

   assign mem_access  = ctl.MEM_R_EN_MEM | ctl.MEM_W_EN_MEM;
   // A ready in the same cycle as the last allowed WAIT cycle counts as a normal completion.
   assign timeout_hit = (state == ST_WAIT) && (wait_cnt == 8'(TIMEOUT - 1)) && !ctl.sram_ready;
   assign mem_busy    = ((state == ST_RUN) && mem_access) || (state == ST_WAIT);

   // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:     if (mem_access) state_nxt = ST_WAIT;
         ST_WAIT:    if (ctl.sram_ready || timeout_hit) state_nxt = ST_RELEASE;
         ST_RELEASE: state_nxt = ST_RUN;
         default:    state_nxt = ST_RUN;
      endcase
   end

   // Control outputs are held inactive while reset is low so a pipe in reset is never frozen.
   always_comb begin
      pc_freeze_c      = 1'b0;
      if_id_freeze_c   = 1'b0;
      id_exe_freeze_c  = 1'b0;
      exe_mem_freeze_c = 1'b0;
      if_id_flush_c    = 1'b0;
      id_exe_bubble_c  = 1'b0;
      if (!rst) begin
         pc_freeze_c = 1'b0;
      end else if (mem_busy) begin
         pc_freeze_c      = 1'b1;
         if_id_freeze_c   = 1'b1;
         id_exe_freeze_c  = 1'b1;
         exe_mem_freeze_c = 1'b1;
      end else if (ctl.hazard_detected) begin
         pc_freeze_c     = 1'b1;
         if_id_freeze_c  = 1'b1;
         id_exe_bubble_c = 1'b1;
      end else if (ctl.branch_taken) begin
         if_id_flush_c = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_RUN;
         wait_cnt      <= 8'd0;
         sram_req_q    <= 1'b0;
         mem_timeout_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         sram_req_q <= (state_nxt == ST_WAIT);
         if (state == ST_RUN && state_nxt == ST_WAIT) begin
            wait_cnt <= 8'd0;
         end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (timeout_hit) begin
            mem_timeout_q <= 1'b1;
         end
      end
   end

   assign ctl.sram_req       = sram_req_q;
   assign ctl.mem_timeout    = mem_timeout_q;
   assign ctl.pc_freeze      = pc_freeze_c;
   assign ctl.IF_ID_freeze   = if_id_freeze_c;
   assign ctl.ID_EXE_freeze  = id_exe_freeze_c;
   assign ctl.EXE_MEM_freeze = exe_mem_freeze_c;
   assign ctl.IF_ID_flush    = if_id_flush_c;
   assign ctl.ID_EXE_bubble  = id_exe_bubble_c;

`ifdef STALL_COUNTER_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 32'd0;
      end else if (pc_freeze_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign ctl.stall_count = stall_cnt_q;
`else
   assign ctl.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a driver applies directed and random stimulus
// and queues the reference model's expectation; a monitor compares on every falling edge.
module tb_pipeline_stall_controller;

   localparam int unsigned TB_TIMEOUT = 4;

   typedef struct {
      string       name;
      logic [7:0]  ctl;
      logic [31:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   // Reference model: waiting/releasing phase, cycles spent waiting, sticky timeout, frozen cycles.
   bit      m_waiting   = 1'b0;
   bit      m_releasing = 1'b0;
   int      m_waited    = 0;
   bit      m_sticky    = 1'b0;
   longint  m_stalls    = 0;

   pipeline_stall_controller_if bus ();

   pipeline_stall_controller #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .ctl (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) $display("FAIL %s: got %h, expected %h", name, act, exp_v);
      else n_pass++;
   endtask

   task automatic step(input string name, input bit hz, input bit br, input bit rd,
                       input bit wr, input bit rdy, input bit rst_v);
      exp_t e;
      bit   mem, busy, pcf, flush, bub;
      @(posedge clk);
      #1;
      bus.hazard_detected = hz;
      bus.branch_taken    = br;
      bus.MEM_R_EN_MEM    = rd;
      bus.MEM_W_EN_MEM    = wr;
      bus.sram_ready      = rdy;
      rst                 = rst_v;
      e.name = name;
      if (!rst_v) begin
         m_waiting = 0; m_releasing = 0; m_waited = 0; m_sticky = 0; m_stalls = 0;
         e.ctl = 8'd0;
         e.cnt = 32'd0;
      end else begin
         mem   = rd | wr;
         busy  = m_waiting || (!m_waiting && !m_releasing && mem);
         pcf   = busy || hz;
         flush = !busy && !hz && br;
         bub   = !busy && hz;
         e.ctl = {m_waiting, pcf, pcf, busy, busy, flush, bub, m_sticky};
`ifdef STALL_COUNTER_EN
         e.cnt = m_stalls[31:0];
`else
         e.cnt = 32'd0;
`endif
         if (pcf && m_stalls < 64'hFFFF_FFFF) m_stalls++;
         if (m_waiting) begin
            m_waited++;
            if (rdy) begin
               m_waiting = 0; m_releasing = 1;
            end else if (m_waited == int'(TB_TIMEOUT)) begin
               m_waiting = 0; m_releasing = 1; m_sticky = 1;
            end
         end else if (m_releasing) begin
            m_releasing = 0;
         end else if (mem) begin
            m_waiting = 1; m_waited = 0;
         end
      end
      sb.push_back(e);
   endtask

   // Monitor: outputs are sampled on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, " ctl"}, 32'({bus.sram_req, bus.pc_freeze, bus.IF_ID_freeze,
                  bus.ID_EXE_freeze, bus.EXE_MEM_freeze, bus.IF_ID_flush,
                  bus.ID_EXE_bubble, bus.mem_timeout}), 32'(e.ctl));
            check({e.name, " stall_count"}, bus.stall_count, e.cnt);
         end
      end
   end

   initial begin
      int drain;
      rst = 1'b0;
      bus.hazard_detected = 1'b0;
      bus.branch_taken    = 1'b0;
      bus.MEM_R_EN_MEM    = 1'b0;
      bus.MEM_W_EN_MEM    = 1'b0;
      bus.sram_ready      = 1'b0;

      step("reset0", 0, 0, 0, 0, 0, 0);
      step("reset1", 1, 1, 1, 0, 1, 0);
      step("idle",   0, 0, 0, 0, 0, 1);

      // Load: ready on the third WAIT cycle, then RELEASE ignores the still-present load.
      step("load_run",     0, 0, 1, 0, 0, 1);
      step("load_wait1",   0, 0, 1, 0, 0, 1);
      step("load_wait2",   0, 0, 1, 0, 0, 1);
      step("load_wait3",   0, 0, 1, 0, 1, 1);
      step("load_release", 0, 0, 1, 0, 0, 1);
      step("load_after",   0, 0, 0, 0, 0, 1);

      step("hazard_and_branch", 1, 1, 0, 0, 0, 1);
      step("branch_only",       0, 1, 0, 0, 0, 1);
      step("after_branch",      0, 0, 0, 0, 0, 1);

      // Ready coinciding with the last allowed WAIT cycle is a normal completion.
      step("edge_run",     0, 0, 0, 1, 0, 1);
      for (int i = 0; i < int'(TB_TIMEOUT) - 1; i++) step("edge_wait", 0, 0, 0, 1, 0, 1);
      step("edge_wait_last", 0, 0, 0, 1, 1, 1);
      step("edge_release", 0, 1, 0, 1, 0, 1);
      step("edge_after",   0, 0, 0, 0, 0, 1);

      // Timeout: ready never arrives, sticky flag persists until reset.
      step("to_run", 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < int'(TB_TIMEOUT); i++) step("to_wait", 0, 0, 0, 1, 0, 1);
      step("to_release", 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 3; i++) step("to_sticky", 0, 0, 0, 0, 0, 1);

      // Reset while waiting, load still asserted: everything drops at once.
      step("rw_run",    0, 0, 1, 0, 0, 1);
      step("rw_wait",   0, 0, 1, 0, 0, 1);
      step("rw_reset",  0, 0, 1, 0, 0, 0);
      step("rw_resume", 0, 0, 0, 0, 0, 1);
      step("rw_run2",   0, 0, 1, 0, 0, 1);
      step("rw_wait2",  0, 0, 1, 0, 1, 1);
      step("rw_rel2",   0, 0, 0, 0, 0, 1);

      // Five hazard cycles plus a two-cycle memory stall.
      step("cnt_reset", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("cnt_hazard", 1, 0, 0, 0, 0, 1);
      step("cnt_mem_run",  0, 0, 1, 0, 0, 1);
      step("cnt_mem_wait", 0, 0, 1, 0, 1, 1);
      step("cnt_release",  0, 0, 0, 0, 0, 1);
      step("cnt_final",    0, 0, 0, 0, 0, 1);

      for (int i = 0; i < 400; i++) begin
         step("random",
              ($urandom_range(3) == 0), ($urandom_range(3) == 0),
              ($urandom_range(3) == 0), ($urandom_range(7) == 0),
              ($urandom_range(2) == 0), ($urandom_range(49) != 0));
      end

      drain = 0;
      while (sb.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      #1;
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
